// File: rtl/mmu_feeder_if.sv
// Control-unit <-> operand feeder bundle: element writes, feed sequencing and
// the skewed operand lanes/status presented to the 2x2 systolic array.
interface mmu_feeder_if #(
    parameter int DATA_W = 8
);
    logic              mem_load_mat;
    logic [2:0]        mem_addr;
    logic [DATA_W-1:0] load_data;
    logic              mmu_en;
    logic [2:0]        mmu_cycle;
    logic [DATA_W-1:0] a_row0;
    logic [DATA_W-1:0] a_row1;
    logic [DATA_W-1:0] b_col0;
    logic [DATA_W-1:0] b_col1;
    logic              feed_valid;
    logic              clear_acc;
    logic              mats_ready;
    logic              feed_done;
    logic              wr_conflict;

    modport master (
        output mem_load_mat, mem_addr, load_data, mmu_en, mmu_cycle,
        input  a_row0, a_row1, b_col0, b_col1,
        input  feed_valid, clear_acc, mats_ready, feed_done, wr_conflict
    );

    modport slave (
        input  mem_load_mat, mem_addr, load_data, mmu_en, mmu_cycle,
        output a_row0, a_row1, b_col0, b_col1,
        output feed_valid, clear_acc, mats_ready, feed_done, wr_conflict
    );
endinterface

// File: rtl/mmu_feeder.sv
// 2x2 matrix operand store with diagonally skewed west/north feed into the MMU.
// Optional FEEDER_WRITE_LOCK_EN: drop writes during feed and flag wr_conflict.
module mmu_feeder #(
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    mmu_feeder_if.slave   bus
);
    logic [DATA_W-1:0] r_mem [8];
    logic [7:0]        r_mask;
    logic              r_prev_en;
    logic [2:0]        r_prev_cyc;

    logic [DATA_W-1:0] r_a_row0, r_a_row1, r_b_col0, r_b_col1;
    logic              r_feed_valid, r_clear_acc, r_mats_ready, r_feed_done;
    logic              r_wr_conflict;

    logic              w_wr_en;
    logic              w_conflict_set;
    logic              w_clr_entry;
    logic              w_done_entry;
    logic [7:0]        w_mask_next;
    logic [DATA_W-1:0] w_a_row0, w_a_row1, w_b_col0, w_b_col1;
    logic              w_feed_valid;

    always_comb begin
`ifdef FEEDER_WRITE_LOCK_EN
        w_wr_en        = bus.mem_load_mat && !bus.mmu_en;
        w_conflict_set = bus.mem_load_mat && bus.mmu_en;
`else
        w_wr_en        = bus.mem_load_mat;
        w_conflict_set = 1'b0;
`endif
        // Pulses fire only on entry to the index, so a stalled control unit cannot repeat them
        w_clr_entry  = bus.mmu_en && (bus.mmu_cycle == 3'd0) &&
                       !(r_prev_en && (r_prev_cyc == 3'd0));
        w_done_entry = bus.mmu_en && (bus.mmu_cycle == 3'd5) &&
                       !(r_prev_en && (r_prev_cyc == 3'd5));

        w_mask_next = w_done_entry ? '0 : r_mask;
        if (w_wr_en) begin
            w_mask_next[bus.mem_addr] = 1'b1;
        end

        w_a_row0     = '0;
        w_a_row1     = '0;
        w_b_col0     = '0;
        w_b_col1     = '0;
        w_feed_valid = 1'b0;
        if (bus.mmu_en) begin
            case (bus.mmu_cycle)
                3'd0: begin
                    w_a_row0     = r_mem[0];
                    w_b_col0     = r_mem[4];
                    w_feed_valid = 1'b1;
                end
                3'd1: begin
                    w_a_row0     = r_mem[1];
                    w_a_row1     = r_mem[2];
                    w_b_col0     = r_mem[6];
                    w_b_col1     = r_mem[5];
                    w_feed_valid = 1'b1;
                end
                3'd2: begin
                    w_a_row1     = r_mem[3];
                    w_b_col1     = r_mem[7];
                    w_feed_valid = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                r_mem[i] <= '0;
            end
            r_mask        <= '0;
            r_prev_en     <= 1'b0;
            r_prev_cyc    <= '0;
            r_a_row0      <= '0;
            r_a_row1      <= '0;
            r_b_col0      <= '0;
            r_b_col1      <= '0;
            r_feed_valid  <= 1'b0;
            r_clear_acc   <= 1'b0;
            r_mats_ready  <= 1'b0;
            r_feed_done   <= 1'b0;
            r_wr_conflict <= 1'b0;
        end else begin
            // Lanes are computed from pre-write contents: same-cycle read sees the old value
            if (w_wr_en) begin
                r_mem[bus.mem_addr] <= bus.load_data;
            end
            r_mask        <= w_mask_next;
            r_prev_en     <= bus.mmu_en;
            r_prev_cyc    <= bus.mmu_cycle;
            r_a_row0      <= w_a_row0;
            r_a_row1      <= w_a_row1;
            r_b_col0      <= w_b_col0;
            r_b_col1      <= w_b_col1;
            r_feed_valid  <= w_feed_valid;
            r_clear_acc   <= w_clr_entry;
            r_mats_ready  <= (w_mask_next == 8'hFF);
            r_feed_done   <= w_done_entry;
            r_wr_conflict <= r_wr_conflict | w_conflict_set;
        end
    end

    assign bus.a_row0      = r_a_row0;
    assign bus.a_row1      = r_a_row1;
    assign bus.b_col0      = r_b_col0;
    assign bus.b_col1      = r_b_col1;
    assign bus.feed_valid  = r_feed_valid;
    assign bus.clear_acc   = r_clear_acc;
    assign bus.mats_ready  = r_mats_ready;
    assign bus.feed_done   = r_feed_done;
    assign bus.wr_conflict = r_wr_conflict;
endmodule

// File: tb/tb_mmu_feeder.sv
// Directed vector bench for mmu_feeder: load, skewed feed, partial load,
// write-during-feed, mid-feed reset and stalled-cycle pulse behaviour.
module tb_mmu_feeder;
`ifdef FEEDER_WRITE_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mmu_feeder_if #(.DATA_W(8)) bus ();

    mmu_feeder #(.DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [2:0] addr;
        logic [7:0] din;
        logic       en;
        logic [2:0] cyc;
        logic [7:0] a0, a1, b0, b1;
        logic       fv, ca, fd, rdy, wc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic ld, input int addr, input int din,
                                input logic en, input int cyc,
                                input int a0, input int a1, input int b0, input int b1,
                                input logic fv, input logic ca, input logic fd,
                                input logic rdy, input logic wc);
        vec_t v;
        v.rst = r;  v.ld = ld; v.addr = 3'(addr); v.din = 8'(din);
        v.en = en;  v.cyc = 3'(cyc);
        v.a0 = 8'(a0); v.a1 = 8'(a1); v.b0 = 8'(b0); v.b1 = 8'(b1);
        v.fv = fv; v.ca = ca; v.fd = fd; v.rdy = rdy; v.wc = wc;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL v%0d.%s: got 0x%0h, expected 0x%0h", idx, name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ld, input logic [2:0] addr,
                         input logic [7:0] din, input logic en, input logic [2:0] cyc);
        @(negedge clk);
        rst              = r;
        bus.mem_load_mat = ld;
        bus.mem_addr     = addr;
        bus.load_data    = din;
        bus.mmu_en       = en;
        bus.mmu_cycle    = cyc;
        @(posedge clk);
        #1;
    endtask

    int done_pulses;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.mem_load_mat = 1'b0;
        bus.mem_addr = '0;
        bus.load_data = '0;
        bus.mmu_en = 1'b0;
        bus.mmu_cycle = '0;

        // reset state
        add(1,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0);
        // full load 1..8, ready only after the eighth write
        for (int i = 0; i < 8; i++)
            add(0,1,i,i+1, 0,0, 0,0,0,0, 0,0,0,(i == 7),0);
        // skewed feed
        add(0,0,0,0, 1,0, 1,0,5,0, 1,1,0,1,0);
        add(0,0,0,0, 1,1, 2,3,7,6, 1,0,0,1,0);
        add(0,0,0,0, 1,2, 0,4,0,8, 1,0,0,1,0);
        add(0,0,0,0, 1,3, 0,0,0,0, 0,0,0,1,0);
        add(0,0,0,0, 1,4, 0,0,0,0, 0,0,0,1,0);
        add(0,0,0,0, 1,5, 0,0,0,0, 0,0,1,0,0);
        add(0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0);
        // out-of-range cycle indices
        add(0,0,0,0, 1,6, 0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 1,7, 0,0,0,0, 0,0,0,0,0);
        // clear_acc single pulse while stalled at 0; values retained after feed_done
        add(0,0,0,0, 1,0, 1,0,5,0, 1,1,0,0,0);
        add(0,0,0,0, 1,0, 1,0,5,0, 1,0,0,0,0);
        add(0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0);
        // reset, partial load, rewrite addr 3
        add(1,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0);
        for (int i = 0; i < 7; i++)
            add(0,1,i,(i+1)*17, 0,0, 0,0,0,0, 0,0,0,0,0);
        add(0,1,3,8'h55, 0,0, 0,0,0,0, 0,0,0,0,0);
        // feed with a write to addr 2 during the same-cycle read of it
        add(0,0,0,0,     1,0, 8'h11,0,8'h55,0,         1,1,0,0,0);
        add(0,1,2,8'hAA, 1,1, 8'h22,8'h33,8'h77,8'h66, 1,0,0,0,LOCK);
        add(0,0,0,0,     1,2, 0,8'h55,0,0,             1,0,0,0,LOCK);
        add(0,0,0,0,     1,1, 8'h22,(LOCK ? 8'h33 : 8'hAA),8'h77,8'h66, 1,0,0,0,LOCK);
        add(0,0,0,0,     0,0, 0,0,0,0, 0,0,0,0,LOCK);
        // complete the load with addr 7
        add(0,1,7,8'h88, 0,0, 0,0,0,0, 0,0,0,1,LOCK);
        // reset mid-feed aborts
        add(0,0,0,0, 1,0, 8'h11,0,8'h55,0, 1,1,0,1,LOCK);
        add(0,0,0,0, 1,1, 8'h22,(LOCK ? 8'h33 : 8'hAA),8'h77,8'h66, 1,0,0,1,LOCK);
        add(1,0,0,0, 1,1, 0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].addr, vecs[i].din, vecs[i].en, vecs[i].cyc);
            check("a_row0",      i, bus.a_row0,      vecs[i].a0);
            check("a_row1",      i, bus.a_row1,      vecs[i].a1);
            check("b_col0",      i, bus.b_col0,      vecs[i].b0);
            check("b_col1",      i, bus.b_col1,      vecs[i].b1);
            check("feed_valid",  i, bus.feed_valid,  vecs[i].fv);
            check("clear_acc",   i, bus.clear_acc,   vecs[i].ca);
            check("feed_done",   i, bus.feed_done,   vecs[i].fd);
            check("mats_ready",  i, bus.mats_ready,  vecs[i].rdy);
            check("wr_conflict", i, bus.wr_conflict, vecs[i].wc);
        end

        // stall at mmu_cycle=5 for three cycles: exactly one feed_done
        done_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd5);
            if (bus.feed_done) done_pulses++;
            check("stall5.feed_done", i, bus.feed_done, (i == 0) ? 1 : 0);
            check("stall5.feed_valid", i, bus.feed_valid, 0);
        end
        check("stall5.pulses", 0, done_pulses, 1);
        drive(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0);
        check("stall5.after", 0, bus.feed_done, 0);

        // element registers were cleared by reset
        drive(1'b0, 1'b0, 3'd0, 8'd0, 1'b1, 3'd1);
        check("post_rst.a_row0", 0, bus.a_row0, 0);
        check("post_rst.b_col1", 0, bus.b_col1, 0);
        drive(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mmu_feeder.md
# mmu_feeder

Matrix operand store and skew feeder sitting directly downstream of the TPU control unit and upstream of the 2x2 systolic MMU. Captures the eight 8-bit matrix elements written under control-unit addressing (A then B). During the MMU feed phase it drives diagonally skewed operand streams into the array's west (A rows) and north (B columns) edges, so each PE accumulates its own c_ij. It also tracks load completeness and write/feed conflicts.

## Interface
Parameters:
- DATA_W, 8, element width in bits

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mem_load_mat  in  1  write strobe from control unit
- mem_addr  in  3  element address: 0..3 = a00,a01,a10,a11; 4..7 = b00,b01,b10,b11
- load_data  in  DATA_W  element value, sampled with mem_load_mat
- mmu_en  in  1  feed phase active (from control unit)
- mmu_cycle  in  3  feed cycle index 0..5 (from control unit)
- a_row0, a_row1  out  DATA_W each  west-edge operands for array rows 0/1
- b_col0, b_col1  out  DATA_W each  north-edge operands for array columns 0/1
- feed_valid  out  1  skewed operands on a_*/b_* are meaningful this cycle
- clear_acc  out  1  one-cycle pulse; PEs zero accumulators before first product
- mats_ready  out  1  all eight elements written since last feed completion
- feed_done  out  1  one-cycle pulse after final feed cycle
- wr_conflict  out  1  sticky flag: write attempted during feed

## Operation
- Storage: eight DATA_W registers plus 8-bit written mask. mem_load_mat=1 writes load_data to element mem_addr and sets mask bit; rewriting an address overwrites, mask unchanged.
- mats_ready = (mask == 8'hFF), registered.
- Feed schedule, keyed on sampled mmu_cycle while mmu_en=1 (unlisted lanes 0):
  - k=0: a_row0=a00, b_col0=b00; clear_acc=1
  - k=1: a_row0=a01, a_row1=a10, b_col0=b10, b_col1=b01
  - k=2: a_row1=a11, b_col1=b11
  - k=3..5: all lanes 0
- feed_valid=1 for k=0..2 only. Gives c00 complete after k=2, c01/c10 after k=3, c11 after k=4.
- k=5 with mmu_en=1: feed_done pulses, mask clears to 0 (mats_ready drops), stored values retained.
- mmu_cycle 6/7 with mmu_en=1: lanes 0, feed_valid 0, no done.
- mmu_en=0: all lanes 0, feed_valid/clear_acc/feed_done 0.
- Feed starting with mats_ready=0 still runs; missing elements read as current register contents (0 after reset).
- Same-cycle write and feed read of one element: feed uses the old value.

## Timing
- All outputs registered; response to inputs sampled at edge N appears after edge N (one-cycle latency). Control-unit cycle k maps to array cycle k+1.
- Reset (sync, rst=1 at edge): all element registers 0, mask 0, all outputs 0, wr_conflict 0. rst mid-feed aborts immediately: no feed_done.
- mats_ready rises one cycle after the eighth distinct address write; falls the cycle feed_done rises.
- feed_done and clear_acc are single-cycle even if mmu_cycle stalls at 5 or 0 (edge-detected on entry to that index).
- wr_conflict clears only on rst.

## Configuration
- FEEDER_WRITE_LOCK_EN defined: writes with mmu_en=1 are dropped (no register or mask change) and set wr_conflict.
- Undefined: writes with mmu_en=1 take effect normally (feed same-cycle rule still applies); wr_conflict tied 0.

## Test plan
- Reset then write addr 0..7 with values 1..8 -> mats_ready=0 until one cycle after addr 7 write, then 1.
- After load, mmu_en=1, mmu_cycle 0..5 -> output cycle 1: (a_row0,a_row1,b_col0,b_col1)=(1,0,5,0), clear_acc=1; cycle 2: (2,3,7,6); cycle 3: (0,4,0,8); cycles 4-6 zeros; feed_done single pulse at cycle 6; mats_ready=0 after.
- Write only addr 0..6 -> mats_ready stays 0; rewrite addr 3 with 0x55 -> stores 0x55, mats_ready still 0.
- Write addr 2 = 0xAA during mmu_en=1 -> with FEEDER_WRITE_LOCK_EN: value unchanged, wr_conflict=1 sticky; without: value 0xAA, wr_conflict=0.
- Assert rst at mmu_cycle=1 -> next cycle all outputs 0, no feed_done, mats_ready 0.
- Hold mmu_cycle=5 with mmu_en=1 for 3 cycles -> feed_done high exactly one cycle.
